// File: rtl/aes_share_codec_pkg.sv
// Shared definitions for the AES share codec: FSM encoding, share indexing, chunk count.
package aes_share_codec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATHER,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_e;

  // Share j of bit b sits at index b*d+j on the shared buses.
  function automatic int unsigned sh_idx(int unsigned b, int unsigned j, int unsigned d);
    return b * d + j;
  endfunction

  function automatic int unsigned num_chunks(int unsigned d, int unsigned rnd_w);
    return (256 * (d - 1)) / rnd_w;
  endfunction

endpackage

// File: rtl/aes_share_codec_rnd_chunk_collector.sv
// Collects PRNG words into the mask register; pulses full when the last chunk is taken.
module rnd_chunk_collector
  import aes_share_codec_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned RND_W = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [RND_W-1:0]       rnd_in,
  output logic [256*(d-1)-1:0]   mask,
  output logic                   full
);

  localparam int unsigned N  = num_chunks(d, RND_W);
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned MW = 256 * (d - 1);

  logic [MW-1:0] mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    full   = 1'b0;
    if (clr) mask_d = '0;
    if (en && rnd_valid) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (cnt_q == CW'(c)) mask_d[c*RND_W +: RND_W] = rnd_in;
      end
      if (cnt_q == CW'(N - 1)) begin
        cnt_d = '0;
        full  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rnd_ready = en;
    mask      = mask_q;
  end

endmodule

// File: rtl/aes_share_codec.sv
// Masking front-end: splits pt/key into d Boolean shares for the core, recombines the ciphertext.
module aes_share_codec
  import aes_share_codec_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned RND_W = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_pt,
  input  logic [127:0]         in_key,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  input  logic [RND_W-1:0]     rnd_in,
  output logic                 core_valid_in,
  input  logic                 core_ready,
  input  logic                 core_cipher_valid,
  output logic [128*d-1:0]     core_sh_pt,
  output logic [128*d-1:0]     core_sh_key,
  input  logic [128*d-1:0]     core_sh_ct,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_ct
);

  localparam int unsigned MW = 256 * (d - 1);

  state_e        state_q, state_d;
  logic [127:0]  pt_q, pt_d, key_q, key_d, ct_q, ct_d;
  logic [MW-1:0] mask;
  logic          full, gather, mask_clr;
  logic          acc_p, acc_k, acc_c;

  rnd_chunk_collector #(.d(d), .RND_W(RND_W)) u_coll (
    .clk       (clk),
    .rst       (rst),
    .en        (gather),
    .clr       (mask_clr),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_in    (rnd_in),
    .mask      (mask),
    .full      (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid)          state_d = ST_GATHER;
      ST_GATHER: if (full)              state_d = ST_ISSUE;
      ST_ISSUE:  if (core_ready)        state_d = ST_WAIT;
      ST_WAIT:   if (core_cipher_valid) state_d = ST_OUT;
      ST_OUT:    if (out_ready)         state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == ST_IDLE);
    gather        = (state_q == ST_GATHER);
    core_valid_in = (state_q == ST_ISSUE);
    out_valid     = (state_q == ST_OUT);
    mask_clr      = (state_q == ST_ISSUE) && core_ready;
    out_ct        = ct_q;
  end

  always_comb begin
    pt_d  = pt_q;
    key_d = key_q;
    ct_d  = ct_q;
    acc_c = 1'b0;
    if (state_q == ST_IDLE && in_valid) begin
      pt_d  = in_pt;
      key_d = in_key;
    end
    if (mask_clr) begin
      pt_d  = '0;
      key_d = '0;
    end
    if (state_q == ST_WAIT && core_cipher_valid) begin
      for (int unsigned b = 0; b < 128; b++) begin
        acc_c = 1'b0;
        for (int unsigned j = 0; j < d; j++) acc_c = acc_c ^ core_sh_ct[sh_idx(b, j, d)];
        ct_d[b] = acc_c;
      end
    end
    if (state_q == ST_OUT && out_ready) ct_d = '0;
  end

  // Share 0 absorbs the data bit XOR all mask shares so the shares recombine to the input.
  always_comb begin
    core_sh_pt  = '0;
    core_sh_key = '0;
    acc_p       = 1'b0;
    acc_k       = 1'b0;
    if (state_q == ST_ISSUE) begin
      for (int unsigned b = 0; b < 128; b++) begin
        acc_p = pt_q[b];
        acc_k = key_q[b];
        for (int unsigned j = 1; j < d; j++) begin
          core_sh_pt[sh_idx(b, j, d)]  = mask[(j-1)*128 + b];
          core_sh_key[sh_idx(b, j, d)] = mask[MW/2 + (j-1)*128 + b];
          acc_p = acc_p ^ mask[(j-1)*128 + b];
          acc_k = acc_k ^ mask[MW/2 + (j-1)*128 + b];
        end
        core_sh_pt[sh_idx(b, 0, d)]  = acc_p;
        core_sh_key[sh_idx(b, 0, d)] = acc_k;
      end
    end
  end

endmodule

// File: tb/tb_aes_share_codec.sv
// Scoreboard bench for aes_share_codec with d=2, RND_W=128 and a scripted core/PRNG stub.
module tb_aes_share_codec;
  import aes_share_codec_pkg::*;

  localparam int unsigned D  = 2;
  localparam int unsigned RW = 128;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [127:0]     in_pt, in_key;
  logic             rnd_valid, rnd_ready;
  logic [RW-1:0]    rnd_in;
  logic             core_valid_in, core_ready, core_cipher_valid;
  logic [128*D-1:0] core_sh_pt, core_sh_key, core_sh_ct;
  logic             out_valid, out_ready;
  logic [127:0]     out_ct;

  aes_share_codec #(.d(D), .RND_W(RW)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pt             (in_pt),
    .in_key            (in_key),
    .rnd_valid         (rnd_valid),
    .rnd_ready         (rnd_ready),
    .rnd_in            (rnd_in),
    .core_valid_in     (core_valid_in),
    .core_ready        (core_ready),
    .core_cipher_valid (core_cipher_valid),
    .core_sh_pt        (core_sh_pt),
    .core_sh_key       (core_sh_key),
    .core_sh_ct        (core_sh_ct),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_ct            (out_ct)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] pt;
    logic [255:0] key;
  } core_exp_t;

  core_exp_t    exp_core[$];
  logic [127:0] exp_out[$];
  core_exp_t    ce;
  logic [127:0] eo;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_core_hs = 0;

  localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] M_A5  = {16{8'hA5}};
  localparam logic [127:0] M_3C  = {16{8'h3C}};
  localparam logic [127:0] P1S0  = 128'ha5b48796e1f0c3d22d3c0f1e69784b5a;
  localparam logic [127:0] K1S0  = 128'h3c3d3e3f38393a3b3435363730313233;
  localparam logic [127:0] CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KEY2  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] M_0F  = {16{8'h0F}};
  localparam logic [127:0] M_F0  = {16{8'hF0}};
  localparam logic [127:0] P2S0  = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] K2S0  = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
  localparam logic [127:0] CT2   = 128'h3925841d02dc09fbdc118597196a0b32;

  function automatic logic [255:0] ilv(logic [127:0] s0, logic [127:0] s1);
    logic [255:0] r;
    r = '0;
    for (int unsigned b = 0; b < 128; b++) begin
      r[sh_idx(b, 0, D)] = s0[b];
      r[sh_idx(b, 1, D)] = s1[b];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (core_valid_in && core_ready) begin
        n_core_hs++;
        if (exp_core.size() == 0) begin
          chk("core_hs_unexpected", 256'd1, 256'd0);
        end else begin
          ce = exp_core.pop_front();
          chk("core_sh_pt", core_sh_pt, ce.pt);
          chk("core_sh_key", core_sh_key, ce.key);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          chk("out_hs_unexpected", 256'd1, 256'd0);
        end else begin
          eo = exp_out.pop_front();
          chk("out_ct", {128'd0, out_ct}, {128'd0, eo});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [127:0] pt, input logic [127:0] key);
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_pt    = '0;
    in_key   = '0;
  endtask

  task automatic return_ct(input logic [127:0] ct);
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_sh_ct        = ilv(ct ^ r, r);
    core_cipher_valid = 1'b1;
    exp_out.push_back(ct);
    tick();
    core_cipher_valid = 1'b0;
    core_sh_ct        = '0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_pt = '0; in_key = '0;
    rnd_valid = 0; rnd_in = '0;
    core_ready = 0; core_cipher_valid = 0; core_sh_ct = '0;
    out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rnd_ready", rnd_ready, 0);
    chk("rst_core_valid", core_valid_in, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ct", out_ct, 0);
    chk("rst_sh_pt", core_sh_pt, 0);
    chk("rst_sh_key", core_sh_key, 0);
    chk("rst_cnt", dut.u_coll.cnt_q, 0);

    // Basic encode / unmask
    exp_core.push_back('{pt: ilv(P1S0, M_A5), key: ilv(K1S0, M_3C)});
    start_txn(PT1, KEY1);
    chk("t1_in_ready_low", in_ready, 0);
    chk("t1_rnd_ready", rnd_ready, 1);
    rnd_valid = 1; rnd_in = M_A5;
    tick();
    chk("t1_cvi_early", core_valid_in, 0);
    rnd_in = M_3C;
    tick();
    rnd_valid = 0;
    chk("t1_cvi_rise", core_valid_in, 1);
    chk("t1_rnd_ready_low", rnd_ready, 0);
    core_ready = 1;
    tick();
    core_ready = 0;
    chk("t1_cvi_drop", core_valid_in, 0);
    chk("t1_sh_pt_zero", core_sh_pt, 0);
    chk("t1_sh_key_zero", core_sh_key, 0);
    return_ct(CT1);
    chk("t1_out_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        core_cipher_valid = 1;
        core_sh_ct = ilv(~CT1, '0);
      end
      tick();
      core_cipher_valid = 0;
      chk("t1_out_ct_hold", out_ct, CT1);
      chk("t1_out_valid_hold", out_valid, 1);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("t1_out_valid_drop", out_valid, 0);
    chk("t1_out_ct_zero", out_ct, 0);
    chk("t1_in_ready_back", in_ready, 1);

    // PRNG stall and core backpressure
    exp_core.push_back('{pt: ilv(P2S0, M_0F), key: ilv(K2S0, M_F0)});
    start_txn(PT2, KEY2);
    rnd_valid = 1; rnd_in = M_0F;
    tick();
    rnd_valid = 0; rnd_in = {32{4'hD}};
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_mask", dut.u_coll.mask_q[127:0], M_0F);
      chk("t2_stall_cvi", core_valid_in, 0);
      tick();
    end
    chk("t2_cvi_before_last", core_valid_in, 0);
    rnd_valid = 1; rnd_in = M_F0;
    tick();
    rnd_valid = 0;
    chk("t2_cvi_rise", core_valid_in, 1);
    chk("t2_mask", dut.u_coll.mask_q, {M_F0, M_0F});
    for (int i = 0; i < 3; i++) begin
      chk("t2_bp_sh_pt", core_sh_pt, ilv(P2S0, M_0F));
      chk("t2_bp_sh_key", core_sh_key, ilv(K2S0, M_F0));
      chk("t2_bp_cvi", core_valid_in, 1);
      tick();
    end
    core_ready = 1;
    tick();
    core_ready = 0;
    chk("t2_sh_pt_zero", core_sh_pt, 0);
    chk("t2_mask_zero", dut.u_coll.mask_q, 0);
    core_ready = 1;
    tick(); tick();
    core_ready = 0;
    chk("t2_one_core_hs", n_core_hs, 2);
    return_ct(CT2);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("t2_out_done", out_valid, 0);

    // Reset in the middle of GATHER
    start_txn(PT2, KEY2);
    rnd_valid = 1; rnd_in = M_0F;
    tick();
    rnd_valid = 0;
    rst = 1;
    #1;
    chk("t3_rst_in_ready", in_ready, 1);
    chk("t3_rst_rnd_ready", rnd_ready, 0);
    chk("t3_rst_cnt", dut.u_coll.cnt_q, 0);
    chk("t3_rst_mask", dut.u_coll.mask_q, 0);
    tick();
    rst = 0;
    tick();
    chk("t3_idle", in_ready, 1);
    exp_core.push_back('{pt: ilv(P1S0, M_A5), key: ilv(K1S0, M_3C)});
    start_txn(PT1, KEY1);
    rnd_valid = 1; rnd_in = M_A5;
    tick();
    chk("t3_needs_fresh", core_valid_in, 0);
    rnd_in = M_3C;
    tick();
    rnd_valid = 0;
    chk("t3_cvi_rise", core_valid_in, 1);
    core_ready = 1;
    tick();
    core_ready = 0;
    return_ct(CT1);
    out_ready = 1;
    tick();
    out_ready = 0;
    tick();

    chk("end_core_q_empty", exp_core.size(), 0);
    chk("end_out_q_empty", exp_out.size(), 0);
    chk("end_core_hs", n_core_hs, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_share_codec.md
# aes_share_codec

Front-end for the masked round-based AES core. It accepts unshared plaintext/key pairs on a valid/ready stream and pulls fresh randomness from the PRNG over the PRNG's out_valid/out_ready handshake, acting as the consumer end of that handshake. It splits the inputs into d Boolean shares and drives them into the core. When the core returns the shared ciphertext, the block recombines the shares and presents the unshared result on an output valid/ready stream.

## Interface
- d, 2: number of shares (≥2).
- RND_W, 128: PRNG output width per handshake; 256*(d-1) must be a multiple of RND_W.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  block can accept a new pair.
- in_pt  in  128  unshared plaintext.
- in_key  in  128  unshared key.
- rnd_valid  in  1  PRNG word available (PRNG out_valid).
- rnd_ready  out  1  block takes PRNG word (to PRNG out_ready).
- rnd_in  in  RND_W  PRNG randomness.
- core_valid_in  out  1  to core valid_in.
- core_ready  in  1  from core ready.
- core_cipher_valid  in  1  from core cipher_valid.
- core_sh_pt  out  128*d  to core sh_plaintext.
- core_sh_key  out  128*d  to core sh_key.
- core_sh_ct  in  128*d  from core sh_ciphertext.
- out_valid  out  1  unshared ciphertext valid.
- out_ready  in  1  downstream accepts.
- out_ct  out  128  unshared ciphertext.

## Operation
- Share layout: share j of bit b sits at index b*d+j. Share 0 = data ^ (XOR of shares 1..d-1).
- Mask register of 256*(d-1) bits. The first 128*(d-1) bits form the plaintext masks; share j (j≥1) of pt bit b = mask[(j-1)*128+b]. The key masks follow at offset 128*(d-1), using the same rule.
- N = 256*(d-1)/RND_W chunks. The chunk counter is ceil(log2 N)+1 bits wide. Chunk c is written to mask[c*RND_W +: RND_W].
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture pt/key and go to GATHER.
  - GATHER: rnd_ready=1. Each rnd_valid stores one chunk and increments cnt. When chunk N-1 is taken, go to ISSUE and clear cnt.
  - ISSUE: core_valid_in=1. Shares are computed combinationally from the pt/key/mask registers. On core_ready, go to WAIT and zero the pt, key and mask registers.
  - WAIT: on core_cipher_valid, capture out_ct = XOR over j of core_sh_ct[b*d+j] for every b, then go to OUT.
  - OUT: out_valid=1. On out_ready, go to IDLE and zero out_ct.
- core_sh_pt and core_sh_key are 0 outside ISSUE.
- core_cipher_valid outside WAIT is ignored.
- in_ready, rnd_ready, core_valid_in and out_valid are decoded from state only and never depend combinationally on their partner signal.

## Timing
- Reset values: state=IDLE, in_ready=1, rnd_ready=0, core_valid_in=0, out_valid=0, out_ct=0, core_sh_*=0, cnt=0, all data and mask registers 0.
- Reset asserted in any state returns to IDLE asynchronously. Masks are zeroed. No partial transaction resumes.
- An input handshake at edge k puts the block in GATHER from k+1. With rnd_valid held high, chunks are taken at edges k+1 through k+N, and core_valid_in rises in the cycle after edge k+N. Each rnd_valid-low cycle adds exactly one cycle.
- In ISSUE, core_valid_in and the shares stay stable until the edge where core_ready=1. Exactly one core start is issued per input.
- core_cipher_valid sampled at edge m gives out_valid=1 from m+1. out_ct is held stable while out_ready=0.
- Throughput is one transaction in flight, so in_ready=0 from GATHER through OUT.

## Structure
- Shared header holds the share-index function (b*d+j), the chunk count N, and the state encoding. The wrapper and testbench use the same header.
- One sub-module, rnd_chunk_collector, holds the mask register, chunk counter and rnd_ready/rnd_valid logic, and raises a `full` pulse on the last chunk. Share split and recombination stay inline in aes_share_codec.

## Test plan
- Reset: hold rst high, then release. All outputs match the reset values, in_ready=1 and rnd_ready=0 in the first cycle.
- Encode, d=2, RND_W=128: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, chunk0=all A5, chunk1=all 3C. Expect sh_pt[2b+1]=A5-pattern bit b, sh_pt[2b]^sh_pt[2b+1]=pt bit b, and the same for the key with 3C. core_valid_in rises 3 cycles after the input handshake.
- PRNG stall: rnd_valid low for 5 cycles between chunk0 and chunk1. core_valid_in is delayed by exactly 5 cycles and the mask contents are unchanged.
- Core backpressure: core_ready low for 3 cycles in ISSUE. Shares stay bit-stable, core_valid_in stays high, and exactly one handshake occurs, after which core_sh_* becomes 0.
- Unmask: the core stub returns shares (69c4e0d86a7b0430d8cdb78070b4c55a ^ R, R) with R random. out_ct=69c4e0d86a7b0430d8cdb78070b4c55a, and it is held with out_ready low for 4 cycles. A spurious cipher_valid while in OUT is ignored.
- Reset mid-GATHER after chunk0: the next cycle shows IDLE, in_ready=1 and cnt=0. A new transaction then needs N fresh chunks.
